// File: rtl/n64_vmux.sv
// N64 digital video bus transmitter: serialises sync+RGB pixels into
// the 4-phase nDSYNC/D stream, with optional horizontal pixel doubling.
module n64_vmux #(
  parameter int                     color_width = 7,
  parameter logic [color_width-1:0] idle_data   = '0
) (
  input  logic                         VCLK,
  input  logic                         nRST,
  input  logic                         en_i,
  input  logic                         pix_valid_i,
  output logic                         pix_ready_o,
  input  logic [4+3*color_width-1:0]   pix_i,
  input  logic                         n15bit_mode_i,
  input  logic                         pixrep_i,
  output logic                         nDSYNC_o,
  output logic [color_width-1:0]       D_o,
  output logic [1:0]                   phase_o,
  output logic                         underrun_o
);

  localparam int PW = 4 + 3*color_width;
  localparam int CW = color_width;
  localparam logic [CW-1:0] LSB2 = CW'(3);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } ph_e;

  ph_e           ph_q, ph_d;
  logic [PW-1:0] cur_q, cur_d;
  logic          rep_q, rep_d;
  logic          n15_q, n15_d;
  logic          prep_q, prep_d;
  logic          nds_q, nds_d;
  logic [CW-1:0] d_q, d_d;
  logic          und_q, und_d;

  logic          fb_cand;
  logic          prep_eff;
  logic          reuse;
  logic          accept;
  logic          boundary;

  function automatic logic [CW-1:0] fmt(
    input logic [CW-1:0] c,
    input logic          full
  );
    return full ? c : (c & ~LSB2);
  endfunction

  // A frame-start pixel carries new modes that already govern its own
  // slot, so a stale pending repeat can be dropped in favour of it.
  assign fb_cand  = pix_valid_i & cur_q[PW-1] & ~pix_i[PW-1];
  assign prep_eff = fb_cand ? pixrep_i : prep_q;
  assign reuse    = prep_eff & ~rep_q;

  assign pix_ready_o = nRST & en_i & (ph_q == PH_B) & ~reuse;
  assign accept      = pix_valid_i & pix_ready_o;
  assign boundary    = accept & cur_q[PW-1] & ~pix_i[PW-1];

  always_comb begin
    ph_d   = ph_q;
    cur_d  = cur_q;
    rep_d  = rep_q;
    n15_d  = n15_q;
    prep_d = prep_q;
    nds_d  = nds_q;
    d_d    = d_q;
    und_d  = und_q;
    if (!en_i) begin
      ph_d   = PH_B;
      rep_d  = 1'b1;
      nds_d  = 1'b1;
      d_d    = idle_data;
      und_d  = 1'b0;
      n15_d  = n15bit_mode_i;
      prep_d = pixrep_i;
    end else begin
      unique case (ph_q)
        PH_B: begin
          ph_d  = PH_SYNC;
          nds_d = 1'b0;
          if (reuse) begin
            rep_d = 1'b1;
          end else if (accept) begin
            cur_d = pix_i;
            rep_d = ~prep_eff;
            if (boundary) begin
              n15_d  = n15bit_mode_i;
              prep_d = pixrep_i;
            end
          end else begin
            cur_d[PW-5:0] = '0;
            und_d         = 1'b1;
            rep_d         = 1'b1;
          end
          d_d = {{(CW-4){1'b0}}, cur_d[PW-1:PW-4]};
        end
        PH_SYNC: begin
          ph_d  = PH_R;
          nds_d = 1'b1;
          d_d   = fmt(cur_q[3*CW-1:2*CW], n15_q);
        end
        PH_R: begin
          ph_d = PH_G;
          d_d  = fmt(cur_q[2*CW-1:CW], n15_q);
        end
        PH_G: begin
          ph_d = PH_B;
          d_d  = fmt(cur_q[CW-1:0], n15_q);
        end
        default: ph_d = PH_B;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      ph_q   <= PH_B;
      cur_q  <= {4'hF, {(PW-4){1'b0}}};
      rep_q  <= 1'b1;
      n15_q  <= 1'b1;
      prep_q <= 1'b0;
      nds_q  <= 1'b1;
      d_q    <= idle_data;
      und_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cur_q  <= cur_d;
      rep_q  <= rep_d;
      n15_q  <= n15_d;
      prep_q <= prep_d;
      nds_q  <= nds_d;
      d_q    <= d_d;
      und_q  <= und_d;
    end
  end

  assign nDSYNC_o   = nds_q;
  assign D_o        = d_q;
  assign phase_o    = ph_q;
  assign underrun_o = und_q;

endmodule

// File: doc/n64_vmux.md
Name: n64_vmux

Overview:
- Transmitter side of the N64 digital video bus. Serialises parallel sync+RGB pixels into the 4-phase VCLK/nDSYNC/D[6:0] stream produced by the RCP.
- Used as a source-synchronous pattern/replay generator feeding the demux path, and as a bus emulator in benches and test builds.
- One pixel occupies 4 VCLK cycles: one sync phase, then R, G and B phases. Optional pixel repetition emulates low-res horizontal doubling.

Parameters:
color_width, 7, bits per colour channel on D and in pix_i
idle_data, 7'h00, D_o value while disabled or in reset

Ports:
VCLK  input  1  video clock; all logic on its rising edge
nRST  input  1  reset, synchronous, active-low
en_i  input  1  transmit enable
pix_valid_i  input  1  pixel offered
pix_ready_o  output  1  pixel accepted this cycle when pix_valid_i&pix_ready_o (combinational)
pix_i  input  25  {nVSYNC,nCLAMP,nHSYNC,nCSYNC,R[6:0],G[6:0],B[6:0]}
n15bit_mode_i  input  1  1: full 7-bit colour; 0: 5-bit colour, D_o[1:0] forced 0
pixrep_i  input  1  1: each accepted pixel is transmitted twice (8 cycles)
nDSYNC_o  output  1  low during the sync phase
D_o  output  7  multiplexed sync/colour data
phase_o  output  2  current output phase: 0 sync, 1 R, 2 G, 3 B
underrun_o  output  1  sticky: a pixel slot found no valid pixel

Behaviour:
- One clock (VCLK). Reset is synchronous, active-low on nRST.
- Reset values: nDSYNC_o=1, D_o=idle_data, phase_o=3 (internal ph=3), underrun_o=0.
- Reset state of the holding register cur: sync=4'hF, colour=0. Pixel repetition flag rep=1. Latched modes: n15=1, prep=0.
- en_i low: ph held at 3, rep=1, nDSYNC_o=1, D_o=idle_data, underrun_o cleared, pix_ready_o=0. Latched modes reload from the inputs every cycle.
- Enabled, phase sequencing on each edge:
  - ph==3: slot boundary. ph<=0, nDSYNC_o<=0, D_o<={3'b000, sync of the new cur}. The new cur is selected as follows.
    - prep=1 and rep=0: cur reused, rep<=1.
    - Otherwise, handshake accept: cur<=pix_i, rep<=0 if prep, else 1.
    - Otherwise (no valid pixel): cur colour<=0, cur sync held, underrun_o<=1, rep<=1.
  - ph==0: ph<=1, nDSYNC_o<=1, D_o<=R.
  - ph==1: D_o<=G.
  - ph==2: D_o<=B.
- Colour formatting: D_o=C when n15=1; {C[6:2],2'b00} when n15=0.
- pix_ready_o = nRST & en_i & (ph==3) & (rep | !prep).
- Latency: sync of an accepted pixel appears on D_o one cycle after the accept edge; R, G and B follow on the next three cycles.
- Mode latching: n15 and prep load from n15bit_mode_i and pixrep_i only on a frame boundary. A frame boundary is an accept where cur nVSYNC=1 and pix_i[24]=0 (nVSYNC negedge). The new modes take effect from that pixel onward. Mid-frame input changes are ignored.
- If pixrep_i changes at a frame boundary while rep=0, the pending repeat is dropped: the boundary pixel is itself accepted.
- Underrun: only evaluated at a slot where a new pixel is due (no underrun during a repeat slot). The stream keeps its 4-cycle cadence with black colour. underrun_o stays 1 until nRST low or en_i low.
- Reset mid-pixel: outputs return to reset values on the next edge. The partial pixel is discarded; the next pixel starts at the sync phase.
- phase_o = ph after the update, i.e. it describes the current D_o content.

Test Plan:
- Reset then en_i=1; offer pix_i={4'b1011,7'h55,7'h2A,7'h7F}, n15bit_mode_i=1 → pix_ready_o=1 in the first cycle. Next 4 cycles: (nDSYNC_o,D_o)=(0,7'h0B),(1,7'h55),(1,7'h2A),(1,7'h7F). pix_ready_o=1 again in the 4th cycle.
- Continuous valid stream of 3 pixels → 12 cycles with no gap, nDSYNC_o low exactly every 4th cycle, underrun_o=0.
- n15bit_mode_i=0 and pixel R=7'h57 → no change mid-frame. After a frame boundary (nVSYNC 1→0 in pix_i), R is sent as 7'h54.
- pixrep_i=1 applied before a frame boundary, pixel B=7'h11 → after the boundary each pixel is transmitted twice (8 cycles). pix_ready_o is high only on every second slot.
- pix_valid_i=0 at a slot with last sync 4'hF → D_o sequence 7'h0F,0,0,0 and underrun_o=1. underrun_o stays 1 after valid resumes and clears when en_i goes low.
- nRST low during the G phase → next edge nDSYNC_o=1, D_o=0, phase_o=3. After release, the first accepted pixel starts with its sync phase.
